// File: rtl/ym_pkg.sv
// Shared decode constants, parameter limits and write-decode types for the
// TurboSound-style multi-YM2149 interface.
package ym_pkg;

  localparam int NUM_YM_MIN  = 1;
  localparam int NUM_YM_MAX  = 4;
  localparam int COVOX_W_MIN = 4;
  localparam int COVOX_W_MAX = 8;

  // A chip-select write to #FFFD carries 11111 in d[7:3] and the inverted
  // chip index in d[1:0]; d[2] is a don't-care.
  localparam logic [4:0] CS_PREFIX = 5'b11111;

  // Port #FE bit positions.
  localparam int BEEPER_BIT  = 4;
  localparam int TAPEOUT_BIT = 3;

  typedef struct packed {
    logic chip_sel;
    logic port_fe;
    logic covox;
  } wr_decode_t;

  function automatic logic [1:0] chip_index(input logic [7:0] data);
    return ~data[1:0];
  endfunction

endpackage

// File: rtl/covox_pwm_dac.sv
// Covox sample double buffer plus free-running PWM encoder; the new sample
// takes effect only at a counter wrap so every PWM period is a clean duty.
module covox_pwm_dac #(
  parameter int COVOX_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [COVOX_W-1:0] sample,
  output logic               pwm
);

  logic [COVOX_W-1:0] pwm_cnt;
  logic [COVOX_W-1:0] covox_next;
  logic [COVOX_W-1:0] covox_cur;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, making the wrap compare and the buffer transfer coherent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt    <= '0;
      covox_next <= '0;
      covox_cur  <= '0;
      pwm        <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + COVOX_W'(1);
      if (load) begin
        covox_next <= sample;
      end
      if (pwm_cnt == '1) begin
        covox_cur <= covox_next;
      end
      pwm <= (pwm_cnt < covox_cur);
    end
  end

endmodule

// File: rtl/ts_multi_ym.sv
// Z80 bus glue for up to four YM2149 chips: shared BC1/BDIR, registered chip
// select, port #FE beeper/tape bits, covox DAC and a glitch-free chip clock.
module ts_multi_ym
  import ym_pkg::*;
#(
  parameter int NUM_YM  = 2,
  parameter int COVOX_W = 8
) (
  input  logic              cpu_clock,
  input  logic              reset,
  input  logic              a0,
  input  logic              a1,
  input  logic              a2,
  input  logic              a14,
  input  logic              a15,
  input  logic              iorq,
  input  logic              wr,
  input  logic              rd,
  input  logic              m1,
  input  logic [7:0]        d,
  input  logic              clk_mode,
  output logic              bc1,
  output logic              bdir,
  output logic              ym_clock,
  output logic [NUM_YM-1:0] ym_sel,
  output logic              ioge_c,
  output logic              beeper,
  output logic              tapeout,
  output logic              covox_pwm
);

  if (NUM_YM < NUM_YM_MIN || NUM_YM > NUM_YM_MAX) begin : g_num_ym_check
    $error("ts_multi_ym: NUM_YM must be in 1..4");
  end
  if (COVOX_W < COVOX_W_MIN || COVOX_W > COVOX_W_MAX) begin : g_covox_w_check
    $error("ts_multi_ym: COVOX_W must be in 4..8");
  end

  logic              ssg;
  logic              wr_act;
  logic              wr_act_d;
  logic              wr_event;
  wr_decode_t        dec;
  logic [1:0]        idx;
  logic              sel_valid;
  logic [NUM_YM-1:0] sel_onehot;
  logic [1:0]        div_cnt;
  logic              mode_r;

  // Reads are not decoded in this revision.
  logic unused_rd;
  assign unused_rd = rd;

  assign ssg    = a15 & ~a1 & ~iorq;
  assign bc1    = ssg & a14 & m1;
  assign bdir   = ssg & ~wr;
  assign ioge_c = a15 & ~a1 & m1;

  // A bus write strobe may last several cycles; act only on its first edge.
  assign wr_act   = ~iorq & ~wr & m1;
  assign wr_event = wr_act & ~wr_act_d;

  // NOTE: always_comb starts from a full default so no path can hold a value
  // and infer a latch.
  always_comb begin
    dec          = '0;
    dec.chip_sel = wr_event & ssg & a14 & (d[7:3] == CS_PREFIX);
    dec.port_fe  = wr_event & ~a0;
    dec.covox    = wr_event & ~a2 & a0;
  end

  assign idx        = chip_index(d);
  assign sel_valid  = (int'(idx) < NUM_YM);
  assign sel_onehot = NUM_YM'(1) << idx;

  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      wr_act_d <= 1'b0;
      ym_sel   <= NUM_YM'(1);
      beeper   <= 1'b0;
      tapeout  <= 1'b0;
    end else begin
      wr_act_d <= wr_act;
      if (dec.chip_sel && sel_valid) begin
        ym_sel <= sel_onehot;
      end
      if (dec.port_fe) begin
        beeper  <= d[BEEPER_BIT];
        tapeout <= d[TAPEOUT_BIT];
      end
    end
  end

  // The divide ratio only changes at the end of a full /4 period, so a mode
  // switch can never chop a ym_clock phase short.
  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      div_cnt  <= 2'b00;
      mode_r   <= 1'b0;
      ym_clock <= 1'b0;
    end else begin
      div_cnt <= div_cnt + 2'd1;
      if (div_cnt == 2'b11) begin
        mode_r <= clk_mode;
      end
      ym_clock <= mode_r ? div_cnt[1] : div_cnt[0];
    end
  end

  covox_pwm_dac #(
    .COVOX_W(COVOX_W)
  ) u_covox (
    .clk    (cpu_clock),
    .rst_n  (reset),
    .load   (dec.covox),
    .sample (d[7 -: COVOX_W]),
    .pwm    (covox_pwm)
  );

endmodule

// File: tb/tb_ts_multi_ym.sv
// Bench for ts_multi_ym: NUM_YM=2 and NUM_YM=4 instances on one shared bus,
// checked against a port-level model, vector tables and timed PWM windows.
module tb_ts_multi_ym;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic        iorq, wr, rd, m1;
  logic [7:0]  d;
  logic        clk_mode;

  logic       bc1_2, bdir_2, ymclk_2, ioge_2, beep_2, tape_2, pwm_2;
  logic [1:0] sel_2;
  logic       bc1_4, bdir_4, ymclk_4, ioge_4, beep_4, tape_4, pwm_4;
  logic [3:0] sel_4;

  int total = 0;
  int bad   = 0;
  int cyc;

  // Port-level model of the bus-visible registers.
  logic [1:0] m_sel2;
  logic [3:0] m_sel4;
  logic       m_beep, m_tape;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  dv;
    bit          is_rd;
    bit          m1v;
    int          len;
    logic [1:0]  e_sel2;
    logic [3:0]  e_sel4;
    logic        e_beep;
    logic        e_tape;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  // Rising edges since reset release; equals the DUT's free-running counters.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  ts_multi_ym #(.NUM_YM(2), .COVOX_W(8)) dut2 (
    .cpu_clock(clk), .reset(rst_n),
    .a0(addr[0]), .a1(addr[1]), .a2(addr[2]), .a14(addr[14]), .a15(addr[15]),
    .iorq(iorq), .wr(wr), .rd(rd), .m1(m1), .d(d), .clk_mode(clk_mode),
    .bc1(bc1_2), .bdir(bdir_2), .ym_clock(ymclk_2), .ym_sel(sel_2),
    .ioge_c(ioge_2), .beeper(beep_2), .tapeout(tape_2), .covox_pwm(pwm_2)
  );

  ts_multi_ym #(.NUM_YM(4), .COVOX_W(8)) dut4 (
    .cpu_clock(clk), .reset(rst_n),
    .a0(addr[0]), .a1(addr[1]), .a2(addr[2]), .a14(addr[14]), .a15(addr[15]),
    .iorq(iorq), .wr(wr), .rd(rd), .m1(m1), .d(d), .clk_mode(clk_mode),
    .bc1(bc1_4), .bdir(bdir_4), .ym_clock(ymclk_4), .ym_sel(sel_4),
    .ioge_c(ioge_4), .beeper(beep_4), .tapeout(tape_4), .covox_pwm(pwm_4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_regs(input string tag, input logic [1:0] s2, input logic [3:0] s4,
                            input logic b, input logic t);
    check({tag, ".sel2"}, sel_2, s2);
    check({tag, ".sel4"}, sel_4, s4);
    check({tag, ".beeper2"}, beep_2, b);
    check({tag, ".beeper4"}, beep_4, b);
    check({tag, ".tapeout"}, tape_4, t);
  endtask

  // Port semantics: #xxFD with A15=1,A14=1 selects a chip; even ports hit #FE;
  // A2=0,A0=1 loads covox (not modelled here, timed windows cover it).
  task automatic model_write(input logic [15:0] a, input logic [7:0] dv);
    int chip;
    if (a[15] && !a[1] && a[14] && dv[7:3] == 5'b11111) begin
      chip = 3 - int'(dv[1:0]);
      if (chip < 2) m_sel2 = 2'(1 << chip);
      m_sel4 = 4'(1 << chip);
    end
    if (!a[0]) begin
      m_beep = dv[4];
      m_tape = dv[3];
    end
  endtask

  task automatic model_reset();
    m_sel2 = 2'b01;
    m_sel4 = 4'b0001;
    m_beep = 1'b0;
    m_tape = 1'b0;
  endtask

  task automatic bus_cycle(input logic [15:0] a, input logic [7:0] dv, input bit is_rd,
                           input bit m1v, input int len);
    logic e_bc1, e_bdir, e_ioge;
    @(negedge clk);
    addr = a; d = dv; m1 = m1v; iorq = 1'b0; wr = is_rd; rd = ~is_rd;
    e_ioge = a[15] & ~a[1] & m1v;
    e_bc1  = a[15] & ~a[1] & a[14] & m1v;
    e_bdir = a[15] & ~a[1] & ~is_rd;
    #1;
    check("bc1", bc1_2, e_bc1);
    check("bdir", bdir_2, e_bdir);
    check("ioge_c", ioge_2, e_ioge);
    check("bc1_4", bc1_4, e_bc1);
    if (!is_rd && m1v) model_write(a, dv);
    repeat (len) @(negedge clk);
    iorq = 1'b1; wr = 1'b1; rd = 1'b1; m1 = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; iorq = 1'b1; wr = 1'b1; rd = 1'b1; m1 = 1'b1; clk_mode = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Counts covox_pwm highs seen after edges first..last (inclusive).
  task automatic pwm_window(input int first, input int last, output int h2, output int h4);
    h2 = 0;
    h4 = 0;
    while (cyc < last) begin
      @(negedge clk);
      if (cyc >= first) begin
        if (pwm_2 === 1'b1) h2++;
        if (pwm_4 === 1'b1) h4++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int h2, h4, exp_ym;
    logic m_mode;

    rst_n = 1'b0; addr = 16'h0000; d = 8'h00;
    iorq = 1'b1; wr = 1'b1; rd = 1'b1; m1 = 1'b1; clk_mode = 1'b0;
    model_reset();

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    check_regs("reset", 2'b01, 4'b0001, 1'b0, 1'b0);
    check("reset.covox_pwm", pwm_2, 1'b0);
    check("reset.ym_clock", ymclk_2, 1'b0);

    // After release ym_clock runs at cpu_clock/2.
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rel.ym_clock", ymclk_4, logic'((cyc - 1) % 2));
      check("rel.covox_pwm", pwm_2, 1'b0);
    end

    // Table-driven bus writes; expectations follow from the cumulative rows.
    vecs[0]  = '{16'hFFFD, 8'hFE, 1'b0, 1'b1, 1, 2'b10, 4'b0010, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFD, 8'hFF, 1'b0, 1'b1, 1, 2'b01, 4'b0001, 1'b0, 1'b0};
    vecs[2]  = '{16'hFFFD, 8'hFC, 1'b0, 1'b1, 2, 2'b01, 4'b1000, 1'b0, 1'b0};
    vecs[3]  = '{16'hFFFD, 8'hFD, 1'b0, 1'b1, 1, 2'b01, 4'b0100, 1'b0, 1'b0};
    vecs[4]  = '{16'h00FE, 8'h18, 1'b0, 1'b1, 2, 2'b01, 4'b0100, 1'b1, 1'b1};
    vecs[5]  = '{16'h00FE, 8'h10, 1'b0, 1'b1, 1, 2'b01, 4'b0100, 1'b1, 1'b0};
    vecs[6]  = '{16'hBFFD, 8'hFE, 1'b0, 1'b1, 1, 2'b01, 4'b0100, 1'b1, 1'b0};
    vecs[7]  = '{16'hFFFD, 8'h0E, 1'b0, 1'b1, 3, 2'b01, 4'b0100, 1'b1, 1'b0};
    vecs[8]  = '{16'hFFFC, 8'hFE, 1'b0, 1'b1, 1, 2'b10, 4'b0010, 1'b1, 1'b1};
    vecs[9]  = '{16'h00FE, 8'h00, 1'b0, 1'b1, 1, 2'b10, 4'b0010, 1'b0, 1'b0};
    vecs[10] = '{16'hFFFD, 8'hFF, 1'b1, 1'b1, 2, 2'b10, 4'b0010, 1'b0, 1'b0};
    vecs[11] = '{16'hFFFD, 8'hFF, 1'b0, 1'b0, 1, 2'b10, 4'b0010, 1'b0, 1'b0};
    vecs[12] = '{16'hFFFD, 8'hFB, 1'b0, 1'b1, 1, 2'b01, 4'b0001, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      bus_cycle(vecs[i].a, vecs[i].dv, vecs[i].is_rd, vecs[i].m1v, vecs[i].len);
      check_regs($sformatf("vec%0d", i), vecs[i].e_sel2, vecs[i].e_sel4,
                 vecs[i].e_beep, vecs[i].e_tape);
    end

    // Long OUT (#FE),#18: update one edge after strobe start, and a data change
    // while the strobe is still low must not be taken as a second write.
    @(negedge clk);
    addr = 16'h00FE; d = 8'h18; iorq = 1'b0; wr = 1'b0; m1 = 1'b1;
    @(negedge clk);
    check("long.beeper", beep_2, 1'b1);
    check("long.tapeout", tape_2, 1'b1);
    d = 8'h00;
    repeat (3) @(negedge clk);
    check("long.one_event_beep", beep_2, 1'b1);
    check("long.one_event_tape", tape_4, 1'b1);
    iorq = 1'b1; wr = 1'b1;
    model_write(16'h00FE, 8'h18);
    @(negedge clk);

    // Randomized bus traffic against the port-level model.
    for (int i = 0; i < 150; i++) begin
      logic [15:0] ra;
      logic [7:0]  rdv;
      bit          r_rd, r_m1;
      int          rlen;
      case ($urandom_range(0, 5))
        0:       ra = 16'hFFFD;
        1:       ra = 16'hBFFD;
        2:       ra = 16'h00FE;
        3:       ra = 16'hFFFC;
        4:       ra = 16'h7FFD;
        default: ra = 16'($urandom);
      endcase
      rdv  = ($urandom_range(0, 1) == 1) ? {5'b11111, 3'($urandom)} : 8'($urandom);
      r_rd = ($urandom_range(0, 3) == 0);
      r_m1 = ($urandom_range(0, 7) != 0);
      rlen = $urandom_range(1, 3);
      bus_cycle(ra, rdv, r_rd, r_m1, rlen);
      check_regs("rand", m_sel2, m_sel4, m_beep, m_tape);
    end

    // Reset during an active write aborts it; the still-low strobe then
    // produces exactly one write on the first edge after release.
    bus_cycle(16'h00FE, 8'h18, 1'b0, 1'b1, 1);
    bus_cycle(16'hFFFD, 8'hFE, 1'b0, 1'b1, 1);
    check_regs("pre_rst", m_sel2, m_sel4, m_beep, m_tape);
    @(negedge clk);
    addr = 16'hFFFD; d = 8'hFC; iorq = 1'b0; wr = 1'b0; m1 = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_regs("midrst", 2'b01, 4'b0001, 1'b0, 1'b0);
    check("midrst.ym_clock", ymclk_2, 1'b0);
    check("midrst.covox_pwm", pwm_4, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rel.sel4", sel_4, 4'b1000);
    check("rst_rel.sel2", sel_2, 2'b01);
    d = 8'hFE;
    @(negedge clk);
    check("rst_rel.one_event", sel_4, 4'b1000);
    iorq = 1'b1; wr = 1'b1;
    @(negedge clk);

    // Covox: OUT (#FB),#80 then #00 then #FF; each takes effect at the next wrap.
    do_reset();
    bus_cycle(16'h00FB, 8'h80, 1'b0, 1'b1, 1);
    pwm_window(4, 256, h2, h4);
    check("covox.before_wrap", h2, 0);
    pwm_window(257, 512, h2, h4);
    check("covox.duty80", h2, 128);
    check("covox.duty80_4", h4, 128);
    bus_cycle(16'h00FB, 8'h00, 1'b0, 1'b1, 1);
    pwm_window(520, 768, h2, h4);
    check("covox.old_until_wrap", h2, 121);
    pwm_window(769, 1024, h2, h4);
    check("covox.duty00", h2, 0);
    check("covox.duty00_4", h4, 0);
    bus_cycle(16'h00FB, 8'hFF, 1'b0, 1'b1, 1);
    pwm_window(1281, 1536, h2, h4);
    check("covox.dutyFF", h2, 255);

    // clk_mode changed at div_cnt==1 takes effect after the next div_cnt==3.
    m_mode = 1'b0;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      exp_ym = m_mode ? (((cyc - 1) / 2) % 2) : ((cyc - 1) % 2);
      check("mode.ym_clock2", ymclk_2, logic'(exp_ym));
      check("mode.ym_clock4", ymclk_4, logic'(exp_ym));
      if ((cyc - 1) % 4 == 3) m_mode = clk_mode;
      if (cyc % 4 == 1) begin
        if (k >= 8 && k < 12)       clk_mode = 1'b1;
        else if (k >= 28 && k < 32) clk_mode = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
